// File: rtl/conv_pkg.sv
// Shared types, FSM encoding and window-count helper for the sliding-window generator.
package conv_pkg;

  localparam int DEF_DATA_BITS = 8;

  typedef logic [DEF_DATA_BITS-1:0]      pixel_t;
  typedef logic signed [DEF_DATA_BITS:0] win_elem_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  function automatic int num_windows(input int w, input int h, input int k, input int s);
    return ((h - k) / s + 1) * ((w - k) / s + 1);
  endfunction

endpackage

// File: rtl/conv_line_shift.sv
// One channel's line-buffer shift chain with a KxK tap view of the window that
// will be complete once the current din is shifted in.
module conv_line_shift #(
  parameter int WIDTH       = 28,
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 7
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   en,
  input  logic [DATA_BITS-1:0]                                   din,
  output logic [FILTER_SIZE*FILTER_SIZE-1:0][DATA_BITS-1:0]      taps
);

  localparam int K     = FILTER_SIZE;
  // din acts as the chain head, so only (K-1)*WIDTH+K-1 positions need storage.
  localparam int DEPTH = (K - 1) * WIDTH + K - 1;

  logic [DATA_BITS-1:0] sr [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar k = 0; k < K; k++) begin : g_col
      localparam int J = (K - 1 - r) * WIDTH + (K - 1 - k);
      if (J == 0) begin : g_head
        assign taps[r*K+k] = din;
      end else begin : g_tap
        assign taps[r*K+k] = sr[J-1];
      end
    end
  end

endmodule

// File: rtl/conv_win_gen.sv
// Multi-channel KxK sliding-window generator with programmable stride and
// valid/ready handshake towards the MAC array.
//   state | meaning
//   IDLE  | waiting for calc_ready to start (or restart) a frame
//   RUN   | accepting pixels, emitting windows
//   DRAIN | last pixel taken, waiting for the final window hand-off
module conv_win_gen
  import conv_pkg::*;
#(
  parameter int WIDTH       = 28,
  parameter int HEIGHT      = 28,
  parameter int DATA_BITS   = 8,
  parameter int FILTER_SIZE = 7,
  parameter int CHANNELS    = 1,
  parameter int STRIDE      = 1
) (
  input  logic                                                        clk,
  input  logic                                                        rst_n,
  input  logic                                                        valid_in,
  input  logic [CHANNELS*DATA_BITS-1:0]                               data_in,
  output logic                                                        buf_ready,
  input  logic                                                        calc_ready,
  output logic                                                        valid_out_buf,
  output logic [CHANNELS-1:0][FILTER_SIZE*FILTER_SIZE-1:0][DATA_BITS:0] data_out,
  output logic [$clog2(HEIGHT)-1:0]                                   win_row,
  output logic [$clog2(WIDTH)-1:0]                                    win_col,
  output logic                                                        frame_done
);

  localparam int K  = FILTER_SIZE;
  localparam int KK = K * K;
  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  state_t                                     state, state_nxt;
  logic [RW-1:0]                              row;
  logic [CW-1:0]                              col;
  logic [PW-1:0]                              row_ph, col_ph;
  logic                                       accept, xfer, emit, last_col, last_row;
  logic [CHANNELS-1:0][KK-1:0][DATA_BITS-1:0] taps;

  assign accept   = valid_in && buf_ready;
  assign xfer     = valid_out_buf && calc_ready;
  assign last_col = (col == CW'(WIDTH - 1));
  assign last_row = (row == RW'(HEIGHT - 1));
  assign emit     = accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1)) &&
                    (row_ph == '0) && (col_ph == '0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    conv_line_shift #(
      .WIDTH       (WIDTH),
      .DATA_BITS   (DATA_BITS),
      .FILTER_SIZE (FILTER_SIZE)
    ) u_shift (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .din   (data_in[c*DATA_BITS +: DATA_BITS]),
      .taps  (taps[c])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    buf_ready  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE:  if (calc_ready) state_nxt = RUN;
      RUN: begin
        buf_ready = !valid_out_buf || calc_ready;
        if (valid_in && buf_ready && last_row && last_col) state_nxt = DRAIN;
      end
      DRAIN: if (!valid_out_buf) begin
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Phase down-counters reach zero on every STRIDE-th position once the window fits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row    <= '0;
      col    <= '0;
      row_ph <= '0;
      col_ph <= '0;
    end else if (accept) begin
      if (last_col) begin
        col    <= '0;
        col_ph <= '0;
        if (last_row) begin
          row    <= '0;
          row_ph <= '0;
        end else begin
          row <= row + 1'b1;
          if (row >= RW'(K - 1))
            row_ph <= (row_ph == '0) ? PW'(STRIDE - 1) : row_ph - 1'b1;
        end
      end else begin
        col <= col + 1'b1;
        if (col >= CW'(K - 1))
          col_ph <= (col_ph == '0) ? PW'(STRIDE - 1) : col_ph - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out_buf <= 1'b0;
      data_out      <= '0;
      win_row       <= '0;
      win_col       <= '0;
    end else if (emit) begin
      valid_out_buf <= 1'b1;
      win_row       <= row - RW'(K - 1);
      win_col       <= col - CW'(K - 1);
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < KK; i++)
          data_out[c][i] <= {1'b0, taps[c][i]};
    end else if (xfer) begin
      valid_out_buf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_win_gen.sv
// Randomized bench for conv_win_gen: two instances (stride 1 and stride 2, three channels)
// checked window by window against an image-array reference model.
module tb_conv_win_gen;

  localparam int W = 28, H = 28, DB = 8, K = 7, CH = 3, KK = K * K, NPIX = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                        valid_in      [2];
  logic [CH*DB-1:0]            data_in       [2];
  logic                        calc_ready    [2];
  logic                        buf_ready     [2];
  logic                        valid_out_buf [2];
  logic                        frame_done    [2];
  logic [CH-1:0][KK-1:0][DB:0] data_out      [2];
  logic [4:0]                  win_row       [2];
  logic [4:0]                  win_col       [2];

  conv_win_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .FILTER_SIZE(K),
                 .CHANNELS(CH), .STRIDE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in[0]), .data_in(data_in[0]),
    .buf_ready(buf_ready[0]), .calc_ready(calc_ready[0]), .valid_out_buf(valid_out_buf[0]),
    .data_out(data_out[0]), .win_row(win_row[0]), .win_col(win_col[0]),
    .frame_done(frame_done[0]));

  conv_win_gen #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .FILTER_SIZE(K),
                 .CHANNELS(CH), .STRIDE(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in[1]), .data_in(data_in[1]),
    .buf_ready(buf_ready[1]), .calc_ready(calc_ready[1]), .valid_out_buf(valid_out_buf[1]),
    .data_out(data_out[1]), .win_row(win_row[1]), .win_col(win_col[1]),
    .frame_done(frame_done[1]));

  int checks = 0;
  int errors = 0;
  int win_total = 0;
  int img [CH][NPIX];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: (p + off + 50*c) % 256, mode 1: random pixels
  task automatic set_pattern(input int mode, input int off);
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < NPIX; p++)
        img[c][p] = (mode == 0) ? (p + off + 50 * c) % 256 : int'($urandom_range(0, 255));
  endtask

  function automatic logic [CH*DB-1:0] pack(input int p);
    logic [CH*DB-1:0] v;
    for (int c = 0; c < CH; c++) v[c*DB +: DB] = 8'(img[c][p]);
    return v;
  endfunction

  task automatic check_reset_outputs(input int sel);
    chk("rst_valid_out", valid_out_buf[sel], 0);
    chk("rst_buf_ready", buf_ready[sel], 0);
    chk("rst_frame_done", frame_done[sel], 0);
    chk("rst_data_nonzero", |data_out[sel], 0);
    chk("rst_win_row", win_row[sel], 0);
    chk("rst_win_col", win_col[sel], 0);
  endtask

  // Runs one frame on instance sel; entered and left right at a falling edge.
  task automatic run_frame(input int sel, input int stride, input int rdy_pct,
                           input int vld_pct, input int hold_at, input int abort_at);
    int nwc, nwin, p, widx, cyc, last_acc, hold_left, h, w, bc, bi;
    bit fd_seen, held, vo, br, acc;
    logic [CH-1:0][KK-1:0][DB:0] exp_d, snap_d;
    logic [4:0] snap_r, snap_c;
    nwc = (W - K) / stride + 1;
    nwin = nwc * ((H - K) / stride + 1);
    p = 0; widx = 0; cyc = 0; last_acc = -1; hold_left = 0; fd_seen = 0; held = 0;
    snap_d = '0; snap_r = '0; snap_c = '0;
    while (!fd_seen && cyc < 8000) begin
      if (abort_at >= 0 && p == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs(sel);
        valid_in[sel] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      vo = valid_out_buf[sel];
      if (hold_at >= 0 && !held && vo && widx >= hold_at) begin
        held = 1; hold_left = 5;
        snap_d = data_out[sel]; snap_r = win_row[sel]; snap_c = win_col[sel];
      end
      calc_ready[sel] = (hold_left > 0) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      valid_in[sel]   = (p < NPIX) && ($urandom_range(0, 99) < vld_pct);
      data_in[sel]    = (p < NPIX) ? pack(p) : (CH*DB)'($urandom);
      #1;
      br = buf_ready[sel];
      if (hold_left > 0) begin
        chk("hold_buf_ready", br, 0);
        if (hold_left < 5) begin
          chk("hold_valid", vo, 1);
          chk("hold_win_row", win_row[sel], snap_r);
          chk("hold_win_col", win_col[sel], snap_c);
          checks++;
          assert (data_out[sel] === snap_d) else begin
            errors++;
            $error("FAIL hold_data observed changed window at hold step %0d expected frozen", 5 - hold_left);
          end
        end
        hold_left--;
      end else if (vo && !calc_ready[sel]) begin
        chk("stall_buf_ready", br, 0);
      end
      if (last_acc == 173) chk("pre_first_valid", vo, 0);
      if (last_acc == 174) chk("first_window_latency", vo, 1);
      if (frame_done[sel]) begin
        fd_seen = 1;
        chk("frame_done_windows", widx, nwin);
        chk("frame_done_pixels", p, NPIX);
      end
      if (vo && calc_ready[sel]) begin
        chk("extra_window", (widx < nwin), 1);
        if (widx < nwin) begin
          h = (widx / nwc) * stride;
          w = (widx % nwc) * stride;
          chk("win_row", win_row[sel], h);
          chk("win_col", win_col[sel], w);
          for (int c = 0; c < CH; c++)
            for (int r = 0; r < K; r++)
              for (int k = 0; k < K; k++)
                exp_d[c][r*K+k] = 9'(img[c][(h + r) * W + w + k]);
          bc = 0; bi = 0;
          for (int c = CH - 1; c >= 0; c--)
            for (int i = KK - 1; i >= 0; i--)
              if (data_out[sel][c][i] !== exp_d[c][i]) begin bc = c; bi = i; end
          checks++;
          assert (data_out[sel] === exp_d) else begin
            errors++;
            $error("FAIL win_data window %0d ch %0d idx %0d observed %0h expected %0h",
                   widx, bc, bi, data_out[sel][bc][bi], exp_d[bc][bi]);
          end
        end
        widx++;
        win_total++;
      end
      acc = valid_in[sel] && br;
      last_acc = acc ? p : -1;
      if (acc) p++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("frame_timeout", fd_seen, 1);
    valid_in[sel]   = 1'b0;
    calc_ready[sel] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      valid_in[s] = 1'b0; calc_ready[s] = 1'b0; data_in[s] = '0;
    end
    #3;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // baseline pattern, stride 1 then stride 2, no backpressure
    set_pattern(0, 0);
    run_frame(0, 1, 100, 100, -1, -1);
    run_frame(1, 2, 100, 100, -1, -1);

    // random pixels with random backpressure, one forced 5-cycle stall
    set_pattern(1, 0);
    run_frame(0, 1, 60, 70, 10, -1);
    set_pattern(1, 0);
    run_frame(1, 2, 50, 80, 3, -1);

    // reset after 300 pixels, then a clean frame
    set_pattern(1, 0);
    run_frame(0, 1, 100, 100, -1, 300);
    set_pattern(0, 0);
    run_frame(0, 1, 100, 100, -1, -1);

    // back-to-back frames
    win_total = 0;
    set_pattern(0, 0);
    run_frame(0, 1, 100, 100, -1, -1);
    set_pattern(0, 7);
    run_frame(0, 1, 85, 100, -1, -1);
    chk("two_frame_windows", win_total, 968);

    repeat (4) begin
      @(negedge clk);
      chk("idle_frame_done", frame_done[0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
